rc_adder_seq_ctrl: RTL and testbench
====================================

// Module: rc_adder_seq_ctrl
// PURPOSE
//   Sequencer that drives one 4-bit ripple-carry adder slice (rc_adder: a, b, c_in -> sum, c_out)
//   nibble-serially to add or subtract WIDTH-bit operands. Accepts one operation per valid/ready
//   handshake, iterates LSB nibble to MSB nibble with a registered carry, and presents the result
//   on a valid/ready output. Sits between an operand source and a result consumer.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of 4, minimum 4 (NIB = WIDTH/4)
// PORTS
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   in_valid  in   1      operands/op_sub/c_in valid
//   in_ready  out  1      block can accept an operation (high only in IDLE)
//   op_a      in   WIDTH  operand A
//   op_b      in   WIDTH  operand B
//   op_sub    in   1      0: A+B+c_in ; 1: A-B (A + ~B + 1, c_in ignored)
//   c_in      in   1      carry in for add
//   out_valid out  1      result/c_out valid
//   out_ready in   1      consumer accepts result
//   result    out  WIDTH  sum/difference
//   c_out     out  1      final carry; for sub, 1 = no borrow (A >= B unsigned)
//   busy      out  1      high in RUN or HOLD
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, c_out=0,
//     nibble index=0, carry reg=0. Reset mid-RUN or mid-HOLD discards the in-flight operation.
//   - FSM: IDLE -> RUN on in_valid & in_ready; RUN -> HOLD after nibble NIB-1; HOLD -> IDLE on out_ready.
//   - IDLE accept edge: latch op_a; latch op_b (bitwise inverted if op_sub); carry reg <= op_sub ? 1 : c_in;
//     index <= 0. in_valid with in_ready=0 is ignored, operands not sampled.
//   - RUN: each cycle slice adds a_reg[4i+:4], b_reg[4i+:4], carry reg; sum nibble written to an internal
//     accumulator at [4i+:4]; carry reg <= slice c_out; index++. Exactly NIB RUN cycles.
//   - Entering HOLD: result <= accumulator (incl. final nibble), c_out <= final slice carry, out_valid <= 1.
//   - result/c_out change only on entry to HOLD or reset; stable in IDLE/RUN and throughout HOLD.
//   - Latency: accept at edge k -> out_valid high after edge k+NIB (WIDTH=16: 4 cycles).
//   - HOLD: out_valid=1 until edge where out_ready=1, then out_valid=0, IDLE. No accept in the same
//     edge; next op accepted at earliest the following edge. Throughput: 1 op per NIB+2 cycles min.
//   - out_ready while out_valid=0: ignored. Overflow (carry beyond WIDTH) reported only via c_out.
// TESTING
//   1. Assert rst during RUN (WIDTH=16) -> out_valid=0, result=0, c_out=0, in_ready=1 without clock edge;
//      fresh op after release completes correctly.
//   2. a=16'hFFFF, b=16'h0001, c_in=0, add -> result=16'h0000, c_out=1, out_valid exactly 4 edges after accept.
//   3. a=16'h0006, b=16'h0008, c_in=1, add -> result=16'h000F, c_out=0.
//   4. Sub: a=16'h0010, b=16'h0001, c_in=1 -> 16'h000F, c_out=1; a=16'h0001, b=16'h0002 -> 16'hFFFF, c_out=0.
//   5. Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid/result/c_out stable, in_ready=0,
//      concurrent in_valid ignored; out_ready=1 -> IDLE, new op accepted next edge.
//   6. WIDTH=4: a=4'b1111, b=4'b0011, c_in=1 -> result=4'b0011, c_out=1, out_valid 1 edge after accept.

Source files
------------

// File: rtl/rc_adder_seq_ctrl.sv
// Nibble-serial add/subtract sequencer around a single 4-bit ripple-carry slice.
// One operation per input handshake; the result is held on a valid/ready output until taken.

module rc_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        c_out = carry[4];
    end
endmodule

// state | meaning
// IDLE  | waiting for an operation, in_ready high
// RUN   | one nibble per cycle through the slice, LSB first
// HOLD  | result presented, waiting for out_ready
module rc_adder_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_sum;
    logic             slice_co;
    logic             accept;
    logic             last_nib;

    rc_adder u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry),
        .sum   (slice_sum),
        .c_out (slice_co)
    );

    assign accept   = in_valid && (state == IDLE);
    assign last_nib = (idx == IW'(NIB - 1));

    always_comb begin
        slice_a  = '0;
        slice_b  = '0;
        acc_next = acc;
        for (int i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) begin
                slice_a           = a_reg[4*i +: 4];
                slice_b           = b_reg[4*i +: 4];
                acc_next[4*i +: 4] = slice_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_nib) state_next = HOLD;
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is folded into the add path as A + ~B + 1 at accept time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            c_out  <= 1'b0;
        end else if (accept) begin
            a_reg <= op_a;
            b_reg <= op_sub ? ~op_b : op_b;
            carry <= op_sub ? 1'b1 : c_in;
            idx   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            carry <= slice_co;
            if (last_nib) begin
                idx    <= '0;
                result <= acc_next;
                c_out  <= slice_co;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rc_adder_seq_ctrl.sv
// Self-checking bench: directed and random operations on WIDTH=16 and WIDTH=4 instances
// compared against arithmetic reference results.

module tb_rc_adder_seq_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, op_sub, c_in, out_ready;
    logic [15:0] op_a, op_b;
    logic        in_ready, out_valid, c_out, busy;
    logic [15:0] result;

    logic        in_valid4, op_sub4, c_in4, out_ready4;
    logic [3:0]  op_a4, op_b4;
    logic        in_ready4, out_valid4, c_out4, busy4;
    logic [3:0]  result4;

    int checks = 0;
    int errors = 0;

    rc_adder_seq_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .c_out(c_out), .busy(busy)
    );

    rc_adder_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .op_a(op_a4), .op_b(op_b4), .op_sub(op_sub4), .c_in(c_in4),
        .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
        .c_out(c_out4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {carry, result}: subtraction reported as modular difference with no-borrow flag.
    function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub, input logic cin);
        int unsigned ua, ub, s;
        ua = a;
        ub = b;
        if (sub) begin
            s = (ua + 65536 - ub) % 65536;
            return {(ua >= ub) ? 1'b1 : 1'b0, s[15:0]};
        end
        s = ua + ub + (cin ? 1 : 0);
        return {(s >= 65536) ? 1'b1 : 1'b0, s[15:0]};
    endfunction

    function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b,
                                          input logic sub, input logic cin);
        int unsigned ua, ub, s;
        ua = a;
        ub = b;
        if (sub) begin
            s = (ua + 16 - ub) % 16;
            return {(ua >= ub) ? 1'b1 : 1'b0, s[3:0]};
        end
        s = ua + ub + (cin ? 1 : 0);
        return {(s >= 16) ? 1'b1 : 1'b0, s[3:0]};
    endfunction

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic cin, input int hold);
        logic [16:0] exp;
        logic [15:0] prev;
        int n;
        exp = model16(a, b, sub, cin);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        prev = result;
        in_valid = 1'b1; op_a = a; op_b = b; op_sub = sub; c_in = cin;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom); c_in = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            chk("busy_run", busy, 1);
            chk("in_ready_run", in_ready, 0);
            chk("result_stable_run", result, prev);
            @(posedge clk); #1;
            n++;
        end
        chk("latency16", n, 4);
        chk("result16", result, exp[15:0]);
        chk("c_out16", c_out, exp[16]);
        repeat (hold) begin
            @(negedge clk);
            in_valid = 1'b1; op_a = 16'($urandom); op_b = 16'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_result", result, exp[15:0]);
            chk("hold_c_out", c_out, exp[16]);
            chk("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("release_busy", busy, 0);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sub, input logic cin);
        logic [4:0] exp;
        int n;
        exp = model4(a, b, sub, cin);
        @(negedge clk);
        chk("in_ready4", in_ready4, 1);
        in_valid4 = 1'b1; op_a4 = a; op_b4 = b; op_sub4 = sub; c_in4 = cin;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency4", n, 1);
        chk("result4", result4, exp[3:0]);
        chk("c_out4", c_out4, exp[4]);
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        chk("release4", out_valid4, 0);
        @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; c_in = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; op_a4 = '0; op_b4 = '0; op_sub4 = 1'b0; c_in4 = 1'b0; out_ready4 = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_c_out", c_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        op16(16'h0006, 16'h0008, 1'b0, 1'b1, 1);
        op16(16'h0010, 16'h0001, 1'b1, 1'b1, 0);
        op16(16'h0001, 16'h0002, 1'b1, 1'b0, 2);
        op16(16'h1234, 16'h0FF0, 1'b0, 1'b0, 5);

        // Reset in the middle of RUN: outputs must clear before any clock edge.
        @(negedge clk);
        in_valid = 1'b1; op_a = 16'hABCD; op_b = 16'h1111; op_sub = 1'b0; c_in = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrun_out_valid", out_valid, 0);
        chk("midrun_result", result, 0);
        chk("midrun_c_out", c_out, 0);
        chk("midrun_in_ready", in_ready, 1);
        chk("midrun_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        op16(16'h7FFF, 16'h8001, 1'b0, 1'b1, 0);

        for (int i = 0; i < 30; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

        op4(4'b1111, 4'b0011, 1'b0, 1'b1);
        op4(4'b0010, 4'b0101, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            op4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
